// File: rtl/addr_ctrl_pkg.sv
// Shared types and constants for the address-bus arbiter and its encoder.
package addr_ctrl_pkg;

  // Width of the per-access wait counter.
  localparam int WAIT_W = 3;

  // Number of requesters competing for the bus.
  localparam int NUM_REQ = 4;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ACC,
    POST,
    ACC2,
    POST2
  } state_e;

  // Bus owner encodings presented on the owner output.
  localparam logic [1:0] OWN_PC = 2'd0;
  localparam logic [1:0] OWN_SP = 2'd1;
  localparam logic [1:0] OWN_SI = 2'd2;
  localparam logic [1:0] OWN_DI = 2'd3;

  // Request vector positions; a lower index has higher priority.
  localparam logic [1:0] REQ_PUSH  = 2'd0;
  localparam logic [1:0] REQ_POP   = 2'd1;
  localparam logic [1:0] REQ_COPY  = 2'd2;
  localparam logic [1:0] REQ_FETCH = 2'd3;

  // Converts a one-hot grant into the request index it selects.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/addr_prio_enc.sv
// Fixed-priority encoder: bit 0 of the request vector always wins.
module addr_prio_enc
  import addr_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               valid_o
);

  // Scan from lowest to highest priority so the highest-priority request is the last one written.
  always_comb begin
    grant_o = '0;
    valid_o = |req_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) grant_o = NUM_REQ'(1) << i;
    end
  end

endmodule

// File: rtl/addr_bus_arbiter.sv
// Address-bus sequencer for the PC/SP/SI/DI register bank and memory strobes.
module addr_bus_arbiter
  import addr_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       fetch_req_i,
  input  logic       push_req_i,
  input  logic       pop_req_i,
  input  logic       copy_req_i,
  output logic       fetch_done_o,
  output logic       push_done_o,
  output logic       pop_done_o,
  output logic       copy_done_o,
  output logic       pc_assert_addr_n_o,
  output logic       sp_assert_addr_n_o,
  output logic       si_assert_addr_n_o,
  output logic       di_assert_addr_n_o,
  output logic       pc_inc_n_o,
  output logic       sp_inc_n_o,
  output logic       sp_dec_n_o,
  output logic       si_inc_n_o,
  output logic       di_inc_n_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       copy_latch_o,
  output logic [1:0] owner_o,
  output logic       busy_o
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [NUM_REQ-1:0]  reqVec;
  logic [NUM_REQ-1:0]  grantVec;
  logic                grantValid;

  assign reqVec[REQ_PUSH]  = push_req_i;
  assign reqVec[REQ_POP]   = pop_req_i;
  assign reqVec[REQ_COPY]  = copy_req_i;
  assign reqVec[REQ_FETCH] = fetch_req_i;

  addr_prio_enc u_prio (
    .req_i   (reqVec),
    .grant_o (grantVec),
    .valid_o (grantValid)
  );

  // State, wait counter and latched transaction type; reset aborts any transaction.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= REQ_PUSH;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Next-state sequencing plus output decode from registered state, counter and transaction only.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    op_d               = op_q;
    fetch_done_o       = 1'b0;
    push_done_o        = 1'b0;
    pop_done_o         = 1'b0;
    copy_done_o        = 1'b0;
    pc_assert_addr_n_o = 1'b1;
    sp_assert_addr_n_o = 1'b1;
    si_assert_addr_n_o = 1'b1;
    di_assert_addr_n_o = 1'b1;
    pc_inc_n_o         = 1'b1;
    sp_inc_n_o         = 1'b1;
    sp_dec_n_o         = 1'b1;
    si_inc_n_o         = 1'b1;
    di_inc_n_o         = 1'b1;
    mem_rd_o           = 1'b0;
    mem_wr_o           = 1'b0;
    copy_latch_o       = 1'b0;
    owner_o            = OWN_PC;
    busy_o             = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (grantValid) begin
          op_d    = onehot_to_idx(grantVec);
          cnt_d   = WAIT_LOAD;
          state_d = grantVec[REQ_PUSH] ? PRE : ACC;
        end
      end
      PRE: begin
        owner_o    = OWN_SP;
        sp_dec_n_o = 1'b0;
        cnt_d      = WAIT_LOAD;
        state_d    = ACC;
      end
      ACC: begin
        if (cnt_q == '0) state_d = POST;
        else cnt_d = cnt_q - 1'b1;
        case (op_q)
          REQ_FETCH: begin
            owner_o            = OWN_PC;
            pc_assert_addr_n_o = 1'b0;
            mem_rd_o           = 1'b1;
          end
          REQ_PUSH: begin
            owner_o            = OWN_SP;
            sp_assert_addr_n_o = 1'b0;
            mem_wr_o           = 1'b1;
          end
          REQ_POP: begin
            owner_o            = OWN_SP;
            sp_assert_addr_n_o = 1'b0;
            mem_rd_o           = 1'b1;
          end
          default: begin
            owner_o            = OWN_SI;
            si_assert_addr_n_o = 1'b0;
            mem_rd_o           = 1'b1;
            copy_latch_o       = (cnt_q == '0);
          end
        endcase
      end
      POST: begin
        state_d = IDLE;
        case (op_q)
          REQ_FETCH: begin
            owner_o      = OWN_PC;
            pc_inc_n_o   = 1'b0;
            fetch_done_o = 1'b1;
          end
          REQ_PUSH: begin
            owner_o     = OWN_SP;
            push_done_o = 1'b1;
          end
          REQ_POP: begin
            owner_o    = OWN_SP;
            sp_inc_n_o = 1'b0;
            pop_done_o = 1'b1;
          end
          default: begin
            owner_o    = OWN_SI;
            si_inc_n_o = 1'b0;
            cnt_d      = WAIT_LOAD;
            state_d    = ACC2;
          end
        endcase
      end
      ACC2: begin
        owner_o            = OWN_DI;
        di_assert_addr_n_o = 1'b0;
        mem_wr_o           = 1'b1;
        if (cnt_q == '0) state_d = POST2;
        else cnt_d = cnt_q - 1'b1;
      end
      POST2: begin
        owner_o     = OWN_DI;
        di_inc_n_o  = 1'b0;
        copy_done_o = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Scoreboard bench for addr_bus_arbiter: three instances with MEM_WAIT = 0, 1 and 2.
module tb_addr_bus_arbiter;

  typedef struct {
    logic [18:0] o;
    logic [15:0] addr;
    string       tag;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        reqFetch[3];
  logic        reqPush[3];
  logic        reqPop[3];
  logic        reqCopy[3];
  logic        fetchDone[3], pushDone[3], popDone[3], copyDone[3];
  logic        pcAsn[3], spAsn[3], siAsn[3], diAsn[3];
  logic        pcInc[3], spInc[3], spDec[3], siInc[3], diInc[3];
  logic        memRd[3], memWr[3], latch[3], busy[3];
  logic [1:0]  owner[3];
  logic [18:0] obs[3];
  logic [15:0] busAddr[3];

  logic [15:0] pcM[3], spM[3], siM[3], diM[3];
  logic        loadModel;
  logic [15:0] ldPc, ldSp, ldSi, ldDi;

  exp_t        expQ[$];
  int          monInst;
  int          checks;
  int          errors;

  localparam logic [18:0] IDLE_OBS = {4'b1111, 5'b11111, 3'b000, 4'b0000, 2'd0, 1'b0};

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    addr_bus_arbiter #(.MEM_WAIT(g)) dut (
      .clk_i              (clk),
      .reset_i            (reset),
      .fetch_req_i        (reqFetch[g]),
      .push_req_i         (reqPush[g]),
      .pop_req_i          (reqPop[g]),
      .copy_req_i         (reqCopy[g]),
      .fetch_done_o       (fetchDone[g]),
      .push_done_o        (pushDone[g]),
      .pop_done_o         (popDone[g]),
      .copy_done_o        (copyDone[g]),
      .pc_assert_addr_n_o (pcAsn[g]),
      .sp_assert_addr_n_o (spAsn[g]),
      .si_assert_addr_n_o (siAsn[g]),
      .di_assert_addr_n_o (diAsn[g]),
      .pc_inc_n_o         (pcInc[g]),
      .sp_inc_n_o         (spInc[g]),
      .sp_dec_n_o         (spDec[g]),
      .si_inc_n_o         (siInc[g]),
      .di_inc_n_o         (diInc[g]),
      .mem_rd_o           (memRd[g]),
      .mem_wr_o           (memWr[g]),
      .copy_latch_o       (latch[g]),
      .owner_o            (owner[g]),
      .busy_o             (busy[g])
    );

    assign obs[g] = {pcAsn[g], spAsn[g], siAsn[g], diAsn[g],
                     pcInc[g], spInc[g], spDec[g], siInc[g], diInc[g],
                     memRd[g], memWr[g], latch[g],
                     fetchDone[g], pushDone[g], popDone[g], copyDone[g],
                     owner[g], busy[g]};

    assign busAddr[g] = (!pcAsn[g] ? pcM[g] : 16'h0000) | (!spAsn[g] ? spM[g] : 16'h0000) |
                        (!siAsn[g] ? siM[g] : 16'h0000) | (!diAsn[g] ? diM[g] : 16'h0000);
  end

  // Behavioural model of the four address registers, driven only by the DUT strobes.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (loadModel) begin
        pcM[i] <= ldPc;
        spM[i] <= ldSp;
        siM[i] <= ldSi;
        diM[i] <= ldDi;
      end else begin
        if (!pcInc[i]) pcM[i] <= pcM[i] + 16'd1;
        if (!spInc[i]) spM[i] <= spM[i] + 16'd1;
        if (!spDec[i]) spM[i] <= spM[i] - 16'd1;
        if (!siInc[i]) siM[i] <= siM[i] + 16'd1;
        if (!diInc[i]) diM[i] <= diM[i] + 16'd1;
      end
    end
  end

  // Monitor: each cycle with a pending expectation, compare the watched instance and its bus address.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks = checks + 1;
      if (obs[monInst] !== e.o || busAddr[monInst] !== e.addr) begin
        errors = errors + 1;
        $display("[TB] FAIL %s (inst %0d): got outputs=%b addr=%h, expected outputs=%b addr=%h",
                 e.tag, monInst, obs[monInst], busAddr[monInst], e.o, e.addr);
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [18:0] mk(input logic [3:0] asn, input logic [4:0] strN,
                                     input logic rd, input logic wr, input logic lat,
                                     input logic [3:0] dn, input logic [1:0] own);
    return {asn, strN, rd, wr, lat, dn, own, 1'b1};
  endfunction

  task automatic pushExp(input logic [18:0] o, input logic [15:0] addr, input string tag);
    exp_t e;
    e.o    = o;
    e.addr = addr;
    e.tag  = tag;
    expQ.push_back(e);
  endtask

  task automatic expIdle(input string tag);
    pushExp(IDLE_OBS, 16'h0000, tag);
  endtask

  task automatic expPre();
    pushExp(mk(4'b1111, 5'b11011, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1), 16'h0000, "push pre");
  endtask

  task automatic expAcc(input logic [3:0] asn, input logic rd, input logic wr, input logic lat,
                        input logic [1:0] own, input logic [15:0] addr, input string tag);
    pushExp(mk(asn, 5'b11111, rd, wr, lat, 4'b0000, own), addr, tag);
  endtask

  task automatic expPost(input logic [4:0] strN, input logic [3:0] dn, input logic [1:0] own,
                         input string tag);
    pushExp(mk(4'b1111, strN, 1'b0, 1'b0, 1'b0, dn, own), 16'h0000, tag);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int inst, input logic push, input logic pop,
                               input logic copy, input logic fetch);
    reqPush[inst]  = push;
    reqPop[inst]   = pop;
    reqCopy[inst]  = copy;
    reqFetch[inst] = fetch;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic loadRegs(input logic [15:0] pc, input logic [15:0] sp,
                          input logic [15:0] si, input logic [15:0] di);
    ldPc = pc;
    ldSp = sp;
    ldSi = si;
    ldDi = di;
    loadModel = 1'b1;
    tick(1);
    loadModel = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    for (int k = 0; k < 60 && expQ.size() != 0; k++) @(posedge clk);
    #1;
    checks = checks + 1;
    if (expQ.size() != 0) begin
      errors = errors + 1;
      $display("[TB] FAIL %s drain: %0d expectations left, expected 0", tag, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    monInst   = 1;
    reset     = 1'b1;
    loadModel = 1'b1;
    ldPc = 16'h0100; ldSp = 16'hFFFF; ldSi = 16'h2000; ldDi = 16'h3000;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset held with every request high: everything stays idle.
    tick(1);
    loadModel = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 3; i++) checkOutput($sformatf("reset hold inst%0d", i), 32'(obs[i]), 32'(IDLE_OBS));
      tick(1);
    end

    // Reset released: push wins first on the MEM_WAIT=1 instance.
    $display("[TB] reset release, first grant");
    reset = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b0);
    expIdle("post-reset idle");
    expPre();
    expAcc(4'b1011, 1'b0, 1'b1, 1'b0, 2'd1, 16'hFFFE, "push acc");
    expAcc(4'b1011, 1'b0, 1'b1, 1'b0, 2'd1, 16'hFFFE, "push acc");
    expPost(5'b11111, 4'b0100, 2'd1, "push post");
    expIdle("idle after push");
    tick(5);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDrain("first grant");

    // Single fetch, MEM_WAIT=1.
    $display("[TB] fetch W=1");
    loadRegs(16'h0100, 16'hFFFF, 16'h2000, 16'h3000);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1);
    expIdle("fetch idle");
    expAcc(4'b0111, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0100, "fetch acc");
    expAcc(4'b0111, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0100, "fetch acc");
    expPost(5'b01111, 4'b1000, 2'd0, "fetch post");
    expIdle("fetch done idle");
    tick(4);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDrain("fetch");
    checkOutput("pc after fetch", 32'(pcM[1]), 32'h0101);

    // Push and fetch together, MEM_WAIT=1: push first, one idle cycle, then fetch.
    $display("[TB] push+fetch W=1");
    loadRegs(16'h0100, 16'hFFFF, 16'h2000, 16'h3000);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b1);
    expIdle("pf idle");
    expPre();
    expAcc(4'b1011, 1'b0, 1'b1, 1'b0, 2'd1, 16'hFFFE, "pf push acc");
    expAcc(4'b1011, 1'b0, 1'b1, 1'b0, 2'd1, 16'hFFFE, "pf push acc");
    expPost(5'b11111, 4'b0100, 2'd1, "pf push post");
    expIdle("pf gap");
    expAcc(4'b0111, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0100, "pf fetch acc");
    expAcc(4'b0111, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0100, "pf fetch acc");
    expPost(5'b01111, 4'b1000, 2'd0, "pf fetch post");
    expIdle("pf end idle");
    tick(5);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(4);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDrain("push+fetch");
    checkOutput("sp after push", 32'(spM[1]), 32'hFFFE);
    checkOutput("pc after pf fetch", 32'(pcM[1]), 32'h0101);

    // Block copy, MEM_WAIT=0.
    $display("[TB] copy W=0");
    monInst = 0;
    loadRegs(16'h0100, 16'hFFFF, 16'h2000, 16'h3000);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
    expIdle("copy idle");
    expAcc(4'b1101, 1'b1, 1'b0, 1'b1, 2'd2, 16'h2000, "copy read");
    expPost(5'b11101, 4'b0000, 2'd2, "copy si post");
    expAcc(4'b1110, 1'b0, 1'b1, 1'b0, 2'd3, 16'h3000, "copy write");
    expPost(5'b11110, 4'b0001, 2'd3, "copy di post");
    expIdle("copy done idle");
    tick(5);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDrain("copy");
    checkOutput("si after copy", 32'(siM[0]), 32'h2001);
    checkOutput("di after copy", 32'(diM[0]), 32'h3001);

    // Pop on MEM_WAIT=2 aborted by reset in its second access cycle.
    $display("[TB] pop W=2 with reset abort");
    monInst = 2;
    loadRegs(16'h0100, 16'hFFFF, 16'h2000, 16'h3000);
    applyStimulus(2, 1'b0, 1'b1, 1'b0, 1'b0);
    expIdle("abort idle");
    expAcc(4'b1011, 1'b1, 1'b0, 1'b0, 2'd1, 16'hFFFF, "abort acc1");
    expAcc(4'b1011, 1'b1, 1'b0, 1'b0, 2'd1, 16'hFFFF, "abort acc2");
    expIdle("abort after reset");
    expIdle("abort idle2");
    expIdle("abort idle3");
    tick(2);
    reset = 1'b1;
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    reset = 1'b0;
    waitDrain("reset abort");
    checkOutput("sp after aborted pop", 32'(spM[2]), 32'hFFFF);

    // Pop request dropped during access, MEM_WAIT=1: still completes, then stays idle.
    $display("[TB] pop W=1 dropped mid-access");
    monInst = 1;
    loadRegs(16'h0100, 16'h1000, 16'h2000, 16'h3000);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0);
    expIdle("drop idle");
    expAcc(4'b1011, 1'b1, 1'b0, 1'b0, 2'd1, 16'h1000, "drop acc");
    expAcc(4'b1011, 1'b1, 1'b0, 1'b0, 2'd1, 16'h1000, "drop acc");
    expPost(5'b10111, 4'b0010, 2'd1, "drop post");
    expIdle("drop idle after");
    expIdle("drop idle after");
    expIdle("drop idle after");
    tick(1);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDrain("drop");
    checkOutput("sp after pop", 32'(spM[1]), 32'h1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
